// File: rtl/spi_slave_tx_ctrl.sv
// Transmit sequencer for the SPI slave shifter.
// Takes a read command, waits out the dummy phase, then feeds 32-bit words
// from the TX FIFO to the shifter with no gap between words.
// The whole block runs on sclk. Chip select high (inactive) is its reset.
//
// state | meaning
// IDLE  | waiting for a read command
// DUMMY | counting dummy sclk cycles before the first word
// LOAD  | first word slot, loads the shifter unconditionally
// SHIFT | shifter busy; chains the next word in the cycle of tx_done
module spi_slave_tx_ctrl #(
  parameter int LEN_W   = 16,
  parameter int DUMMY_W = 8
) (
  input  logic               sclk,
  input  logic               cs,
  input  logic               cmd_start,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [DUMMY_W-1:0] cmd_dummy,
  input  logic               cmd_quad,
  input  logic [31:0]        fifo_data,
  input  logic               fifo_valid,
  output logic               fifo_pop,
  output logic [31:0]        tx_data,
  output logic               tx_data_valid,
  output logic [7:0]         tx_counter_in,
  output logic               tx_counter_upd,
  output logic               tx_en_quad,
  input  logic               tx_done,
  output logic               busy,
  output logic               underrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DUMMY = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   words_left_q, words_left_d;
  logic [DUMMY_W-1:0] dummy_cnt_q, dummy_cnt_d;
  logic               quad_q, quad_d;
  logic               busy_q, busy_d;
  logic               underrun_q, underrun_d;
  logic               load;

  // Next-state logic; 'load' marks a word slot handed to the shifter this cycle.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    dummy_cnt_d  = dummy_cnt_q;
    quad_d       = quad_q;
    underrun_d   = underrun_q;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        // A zero-length command is dropped entirely, nothing gets latched.
        if (cmd_start && (cmd_len != '0)) begin
          words_left_d = cmd_len;
          dummy_cnt_d  = cmd_dummy;
          quad_d       = cmd_quad;
          state_d      = (cmd_dummy != '0) ? DUMMY : LOAD;
        end
      end
      DUMMY: begin
        if (dummy_cnt_q != '0) begin
          dummy_cnt_d = dummy_cnt_q - DUMMY_W'(1);
        end
        if (dummy_cnt_q <= DUMMY_W'(1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (tx_done) begin
          if (words_left_q != '0) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An empty-FIFO slot still consumes a word of the count.
    if (load && (words_left_q != '0)) begin
      words_left_d = words_left_q - LEN_W'(1);
    end
    if (load && !fifo_valid) begin
      underrun_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // State and latched command fields; cs high clears everything at once.
  always_ff @(posedge sclk or posedge cs) begin
    if (cs) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      dummy_cnt_q  <= '0;
      quad_q       <= 1'b0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      dummy_cnt_q  <= dummy_cnt_d;
      quad_q       <= quad_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
    end
  end

  // Load strobes are combinational so a word can chain in the tx_done cycle.
  always_comb begin
    tx_data_valid  = load;
    tx_counter_upd = load;
    fifo_pop       = load && fifo_valid;
    tx_data        = (load && fifo_valid) ? fifo_data : 32'h0;
    tx_counter_in  = quad_q ? 8'd7 : 8'd31;
    tx_en_quad     = quad_q;
    busy           = busy_q;
    underrun       = underrun_q;
  end

endmodule

// File: tb/tb_spi_slave_tx_ctrl.sv
// Self-checking bench for spi_slave_tx_ctrl: FIFO and shifter models in the bench,
// expectations taken from a per-command word list built from the FIFO contents.
module tb_spi_slave_tx_ctrl;

  logic        sclk;
  logic        cs;
  logic        cmd_start;
  logic [15:0] cmd_len;
  logic [7:0]  cmd_dummy;
  logic        cmd_quad;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_pop;
  logic [31:0] tx_data;
  logic        tx_data_valid;
  logic [7:0]  tx_counter_in;
  logic        tx_counter_upd;
  logic        tx_en_quad;
  logic        tx_done;
  logic        busy;
  logic        underrun;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] fq [$];
  logic        last_pop;
  logic [31:0] tmp_w;

  spi_slave_tx_ctrl #(.LEN_W(16), .DUMMY_W(8)) dut (
    .sclk           (sclk),
    .cs             (cs),
    .cmd_start      (cmd_start),
    .cmd_len        (cmd_len),
    .cmd_dummy      (cmd_dummy),
    .cmd_quad       (cmd_quad),
    .fifo_data      (fifo_data),
    .fifo_valid     (fifo_valid),
    .fifo_pop       (fifo_pop),
    .tx_data        (tx_data),
    .tx_data_valid  (tx_data_valid),
    .tx_counter_in  (tx_counter_in),
    .tx_counter_upd (tx_counter_upd),
    .tx_en_quad     (tx_en_quad),
    .tx_done        (tx_done),
    .busy           (busy),
    .underrun       (underrun)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO pops take effect at the posedge after a sampled fifo_pop.
  task automatic apply_pop();
    if (last_pop && fq.size() > 0) tmp_w = fq.pop_front();
    last_pop = 1'b0;
  endtask

  task automatic drive_fifo();
    fifo_valid = (fq.size() > 0);
    fifo_data  = fifo_valid ? fq[0] : $urandom;
  endtask

  // One cycle: drive at negedge, sample 1 ns later.
  task automatic tick(input logic st, input logic dn);
    @(negedge sclk);
    apply_pop();
    drive_fifo();
    cmd_start = st;
    tx_done   = dn;
    #1;
    last_pop = fifo_pop;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, tx_data_valid, 0);
    chk({tag, "_upd"}, tx_counter_upd, 0);
    chk({tag, "_pop"}, fifo_pop, 0);
    chk({tag, "_data"}, tx_data, 32'h0);
    chk({tag, "_quad"}, tx_en_quad, 0);
    chk({tag, "_cnt_in"}, tx_counter_in, 31);
    chk({tag, "_underrun"}, underrun, 0);
  endtask

  task automatic do_reset();
    @(negedge sclk);
    apply_pop();
    drive_fifo();
    cs = 1'b1; cmd_start = 1'b0; tx_done = 1'b0;
    #1;
    check_reset("rst");
    @(negedge sclk);
    cs = 1'b0;
  endtask

  // Runs one read command against the shifter model.
  // Slot k carries the k-th FIFO word present at command start, or zero past the end.
  task automatic run_cmd(input int len, input int dum, input bit quad, input int npush,
                         input bit rst_first, input int abort_k, input bit restart);
    logic [31:0] exp_w [$];
    int nf, t, gap;
    if (rst_first) do_reset();
    for (int i = 0; i < npush; i++) fq.push_back($urandom);
    nf = fq.size();
    for (int i = 0; i < len; i++) exp_w.push_back((i < nf) ? fq[i] : 32'h0);
    cmd_len = 16'(len); cmd_dummy = 8'(dum); cmd_quad = quad;
    tick(1'b1, 1'b0);
    chk("start_busy", busy, 0);
    t = 0;
    do begin
      tick(1'b0, 1'b0);
      t++;
    end while (!tx_data_valid && t <= dum + 8);
    chk("first_load_lat", t, dum + 1);
    for (int k = 0; k < len; k++) begin
      chk("load_valid", tx_data_valid, 1);
      chk("load_upd", tx_counter_upd, 1);
      chk("load_data", tx_data, exp_w[k]);
      chk("load_pop", fifo_pop, (k < nf) ? 1 : 0);
      chk("cnt_in", tx_counter_in, quad ? 7 : 31);
      chk("en_quad", tx_en_quad, quad);
      chk("busy", busy, 1);
      gap = $urandom_range(0, 3);
      if ((restart || k == abort_k) && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin
        if (restart && k == 0 && g == 0) begin
          cmd_len = 16'(len + 5); cmd_quad = ~quad; cmd_dummy = 8'd0;
          tick(1'b1, 1'b0);
        end else begin
          tick(1'b0, 1'b0);
        end
        chk("shift_idle", tx_data_valid, 0);
        chk("shift_nopop", fifo_pop, 0);
      end
      if (k == abort_k) begin
        #2 cs = 1'b1;
        #1;
        check_reset("abort");
        @(negedge sclk);
        cs = 1'b0;
        return;
      end
      tick(1'b0, 1'b1);
    end
    chk("end_noload", tx_data_valid, 0);
    chk("end_nopop", fifo_pop, 0);
    tick(1'b0, 1'b0);
    chk("end_busy", busy, 0);
    chk("end_valid", tx_data_valid, 0);
    chk("underrun", underrun, (len > nf) ? 1 : 0);
  endtask

  initial begin
    cs = 1'b1; cmd_start = 1'b0; cmd_len = '0; cmd_dummy = '0; cmd_quad = 1'b0;
    fifo_data = '0; fifo_valid = 1'b0; tx_done = 1'b0; last_pop = 1'b0;

    // Single lane, no dummy, three known words
    do_reset();
    fq.push_back(32'hA5A5A5A5);
    fq.push_back(32'h12345678);
    fq.push_back(32'hDEADBEEF);
    run_cmd(3, 0, 1'b0, 0, 1'b0, -1, 1'b0);

    // Quad with four dummy cycles
    run_cmd(2, 4, 1'b1, 2, 1'b1, -1, 1'b0);

    // Underrun on the second slot, sticky until cs
    run_cmd(2, 0, 1'b0, 1, 1'b1, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0);
      chk("underrun_sticky", underrun, 1);
    end
    do_reset();

    // Zero-length command is dropped
    fq.push_back($urandom);
    cmd_len = 16'd0; cmd_dummy = 8'(3 - $urandom_range(0, 3)); cmd_quad = 1'b1;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0);
      chk("len0_busy", busy, 0);
      chk("len0_valid", tx_data_valid, 0);
      chk("len0_pop", fifo_pop, 0);
    end

    // Abort during word 2 of 4, then a fresh command picks up the rest
    run_cmd(4, 0, 1'($urandom_range(0, 1)), 4, 1'b1, 1, 1'b0);
    run_cmd(2, 0, 1'b0, 0, 1'b0, -1, 1'b0);

    // Second cmd_start mid-command is ignored
    run_cmd(3, 2, 1'b1, 3, 1'b1, -1, 1'b1);

    // Randomized commands
    for (int r = 0; r < 8; r++) begin
      int l;
      l = $urandom_range(1, 5);
      run_cmd(l, $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom_range(0, l + 1),
              1'b1, -1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
